uart_tx_fifo: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 uart_interface TX path.

---
 rtl/uart_tx_fifo.sv | 115 +++++++++++
 tb/tb_uart_tx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a TX FIFO, frames sent back-to-back.
// Parity and stop-bit count are captured per frame at the moment its byte is popped.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         transmit,
    input  logic [DATA_BITS-1:0]         TxData,
    input  logic [1:0]                   parity_mode,
    input  logic                         two_stop,
    output logic                         TxD,
    output logic                         busy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);
    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(DIVISOR);
    localparam int AW      = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state, w_next;
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wptr, r_rptr;
    logic [AW:0]          r_count;
    logic [CW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en, r_par, r_two, r_stop2, r_txd, r_overflow;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_push, w_pop, w_tick, w_txd, w_last_stop;

    assign fifo_empty  = r_count == '0;
    assign fifo_full   = r_count == (AW+1)'(FIFO_DEPTH);
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign TxD         = r_txd;
    assign busy        = r_state != S_IDLE;
    assign w_head      = r_mem[r_rptr];
    assign w_tick      = r_baud == CW'(DIVISOR - 1);
    assign w_last_stop = w_tick && (r_stop2 || !r_two);
    assign w_push      = transmit && (!fifo_full || w_pop);

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pop  = !fifo_empty;
                w_next = fifo_empty ? S_IDLE : S_START;
            end
            S_START:  w_next = w_tick ? S_DATA : S_START;
            S_DATA:   w_next = (w_tick && r_bit == 4'(DATA_BITS - 1)) ? (r_par_en ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: w_next = w_tick ? S_STOP : S_PARITY;
            S_STOP: begin
                w_pop  = w_last_stop && !fifo_empty;
                w_next = !w_last_stop ? S_STOP : (fifo_empty ? S_IDLE : S_START);
            end
            default:  w_next = S_IDLE;
        endcase
        w_txd = (r_state == S_START)  ? 1'b0 :
                (r_state == S_DATA)   ? r_shift[0] :
                (r_state == S_PARITY) ? r_par : 1'b1;
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wptr] <= TxData;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par      <= 1'b0;
            r_two      <= 1'b0;
            r_stop2    <= 1'b0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_txd      <= w_txd;
            r_overflow <= transmit && fifo_full && !w_pop;
            r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // Counter restarts on every pop so each frame is aligned to its own start bit.
            r_baud     <= (r_state == S_IDLE || w_pop || w_tick) ? '0 : r_baud + 1'b1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr   <= r_rptr + 1'b1;
                r_shift  <= w_head;
                r_par_en <= parity_mode == 2'd1 || parity_mode == 2'd2;
                r_par    <= (parity_mode == 2'd1) ? ~^w_head : ^w_head;
                r_two    <= two_stop;
                r_bit    <= '0;
                r_stop2  <= 1'b0;
            end else if (w_tick) begin
                if (r_state == S_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 1'b1;
                end
                if (r_state == S_STOP) r_stop2 <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: drives uart_tx_fifo (8-bit and 9-bit builds, DIVISOR=10) and checks every
// line cycle against frames built from the bit-level framing rules.
module tb_uart_tx_fifo;
    localparam int BT = 10;

    logic       clk = 0, reset = 0, transmit = 0, two_stop = 0, transmit9 = 0;
    logic [7:0] TxData = 0;
    logic [8:0] TxData9 = 0;
    logic [1:0] parity_mode = 0;
    logic       TxD, busy, fifo_full, fifo_empty, overflow;
    logic [4:0] fifo_count;
    logic       txd9, busy9, full9, empty9, ovf9;
    logic [4:0] count9;
    int         cyc = 0, tests = 0, fails = 0;

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .transmit(transmit), .TxData(TxData), .parity_mode(parity_mode),
        .two_stop(two_stop), .TxD(TxD), .busy(busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .overflow(overflow));

    uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(9), .FIFO_DEPTH(16)) dut9 (
        .clk(clk), .reset(reset), .transmit(transmit9), .TxData(TxData9), .parity_mode(parity_mode),
        .two_stop(two_stop), .TxD(txd9), .busy(busy9), .fifo_full(full9), .fifo_empty(empty9),
        .fifo_count(count9), .overflow(ovf9));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? txd9 : TxD;
    endfunction

    // Call at a negedge; waits for the start bit, then checks every clock of the frame.
    task automatic frame(input bit sel, input logic [8:0] d, input int db, input logic [1:0] pm,
                         input bit two, output int t0);
        logic [15:0] eb;
        logic [8:0]  m;
        int          n, bad, k;
        m  = 9'((1 << db) - 1);
        eb = '0;
        for (int i = 0; i < db; i++) eb[1+i] = d[i];
        n = 1 + db;
        if (pm == 2'd1 || pm == 2'd2) begin
            eb[n] = (pm == 2'd2) ? ($countones(d & m) % 2 == 1) : ($countones(d & m) % 2 == 0);
            n++;
        end
        eb[n] = 1'b1;
        n++;
        if (two) begin
            eb[n] = 1'b1;
            n++;
        end
        k = 0;
        while (line(sel) == 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (k >= 400) begin
            chk("start_timeout", 1, 0);
            t0 = -1;
            return;
        end
        t0  = cyc;
        bad = 0;
        for (int b = 0; b < n; b++)
            for (int c = 0; c < BT; c++) begin
                if (line(sel) !== eb[b]) bad++;
                if (!(b == n - 1 && c == BT - 1)) @(negedge clk);
            end
        chk($sformatf("frame_bits_%0h", d), bad, 0);
    endtask

    task automatic wr(input logic [7:0] d);
        @(negedge clk);
        transmit = 1;
        TxData   = d;
    endtask

    task automatic wr_end();
        @(negedge clk);
        transmit = 0;
    endtask

    initial begin
        int         t, tp, wc, bc, maxc, fulls, ovc, nb;
        logic [7:0] bq [4];
        logic [1:0] rpm;
        bit         rtwo;

        repeat (3) @(negedge clk);
        chk("rst_txd", TxD, 1);
        chk("rst_busy", busy, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1;
        repeat (2) @(negedge clk);

        parity_mode = 0; two_stop = 0;
        wr(8'h55); wr_end(); wc = cyc;
        fork
            frame(0, 9'h55, 8, 0, 0, t);
            begin
                bc = 0;
                repeat (120) begin
                    if (busy) bc++;
                    @(negedge clk);
                end
            end
        join
        chk("latency_55", t - wc, 2);
        chk("busy_len_55", bc, 100);

        parity_mode = 2;
        wr(8'h07); wr_end();
        fork
            frame(0, 9'h07, 8, 2, 0, t);
            begin
                bc = 0;
                repeat (130) begin
                    if (busy) bc++;
                    @(negedge clk);
                end
            end
        join
        chk("busy_len_par", bc, 110);
        parity_mode = 1;
        wr(8'h07); wr_end();
        frame(0, 9'h07, 8, 1, 0, t);
        parity_mode = 2;
        wr(8'h07); wr_end();
        fork
            frame(0, 9'h07, 8, 2, 0, t);
            begin
                repeat (40) @(negedge clk);
                parity_mode = 1;
            end
        join
        parity_mode = 0;
        repeat (5) @(negedge clk);

        maxc = 0; fulls = 0; ovc = 0;
        fork
            for (int i = 0; i < 24; i++) begin
                @(negedge clk);
                if (fifo_count > maxc) maxc = fifo_count;
                if (fifo_full) fulls++;
                if (overflow) ovc++;
                transmit = (i < 18);
                TxData   = 8'(i);
            end
            for (int j = 0; j < 17; j++) begin
                frame(0, 9'(j), 8, 0, 0, t);
                if (j > 0) chk($sformatf("gap_%0d", j), t - tp, 100);
                tp = t;
            end
        join
        chk("peak_count", maxc, 16);
        chk("full_seen", fulls != 0, 1);
        chk("overflow_pulses", ovc, 1);
        repeat (5) @(negedge clk);
        chk("drained_empty", fifo_empty, 1);

        wr(8'hA5);
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        wr_end();
        repeat (41) @(negedge clk);
        chk("queued", fifo_count, 4);
        chk("bit3_a5", TxD, 0);
        reset = 0;
        #1;
        chk("abort_txd", TxD, 1);
        chk("abort_count", fifo_count, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        chk("post_rst_txd", TxD, 1);
        wr(8'h3C); wr_end(); wc = cyc;
        frame(0, 9'h3C, 8, 0, 0, t);
        chk("latency_3c", t - wc, 2);

        two_stop = 1;
        fork
            begin
                wr(8'hFF); wr(8'h00); wr_end();
            end
            begin
                frame(0, 9'hFF, 8, 0, 1, tp);
                frame(0, 9'h00, 8, 0, 1, t);
            end
        join
        chk("two_stop_gap", t - tp, 110);
        two_stop = 0;
        repeat (5) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            nb   = int'($urandom_range(1, 4));
            rpm  = 2'($urandom);
            rtwo = 1'($urandom);
            for (int i = 0; i < 4; i++) bq[i] = 8'($urandom);
            parity_mode = rpm;
            two_stop    = rtwo;
            fork
                begin
                    for (int i = 0; i < nb; i++) wr(bq[i]);
                    wr_end();
                end
                for (int i = 0; i < nb; i++) begin
                    frame(0, {1'b0, bq[i]}, 8, rpm, rtwo, t);
                    if (i > 0)
                        chk("rand_gap", t - tp, BT * (10 + ((rpm == 2'd1 || rpm == 2'd2) ? 1 : 0) + (rtwo ? 1 : 0)));
                    tp = t;
                end
            join
            repeat (3) @(negedge clk);
        end
        chk("rand_idle", busy, 0);

        parity_mode = 1; two_stop = 0;
        @(negedge clk);
        transmit9 = 1;
        TxData9   = 9'h1AB;
        @(negedge clk);
        transmit9 = 0;
        wc = cyc;
        frame(1, 9'h1AB, 9, 1, 0, t);
        chk("latency_9bit", t - wc, 2);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
